// File: rtl/serial_sub.sv
// +----------------------------------------------------------------------------+
// | serial_sub : bit-serial N-bit subtractor, D = A - B, one bit per clock,    |
// |              LSB first, start/done handshake. Optional SERIAL_SUB_FLAGS_EN |
// |              adds registered zero/ovf flags.                               |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_sub #(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         busy,
  output logic         done
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic         zero,
  output logic         ovf
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   ra_q, ra_d;
  logic [N-1:0]   rb_q, rb_d;
  logic [N-1:0]   res_q, res_d;
  logic           br_q, br_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   d_q, d_d;
  logic           bout_q, bout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic           w_x, w_y, w_s, w_br_next;
  logic [N-1:0]   w_res_shift;

`ifdef SERIAL_SUB_FLAGS_EN
  // Operand sign bits are shifted out of ra/rb during RUN, so keep them apart.
  logic           a_msb_q, a_msb_d;
  logic           b_msb_q, b_msb_d;
  logic           zero_q, zero_d;
  logic           ovf_q, ovf_d;
`endif

  // Full-subtractor slice.
  assign w_x         = ra_q[0];
  assign w_y         = rb_q[0];
  assign w_s         = w_x ^ w_y ^ br_q;
  assign w_br_next   = (~w_x & w_y) | (~(w_x ^ w_y) & br_q);
  assign w_res_shift = {w_s, res_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef SERIAL_SUB_FLAGS_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
`ifdef SERIAL_SUB_FLAGS_EN
          a_msb_d = a[N-1];
          b_msb_d = b[N-1];
`endif
        end
      end

      S_RUN: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        res_d = w_res_shift;
        br_d  = w_br_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == C_LAST) begin
          d_d     = w_res_shift;
          bout_d  = w_br_next;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = (w_res_shift == '0);
          ovf_d   = (a_msb_q != b_msb_q) & (w_res_shift[N-1] != a_msb_q);
`endif
        end
      end

      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign d    = d_q;
  assign bout = bout_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero = zero_q;
  assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// +----------------------------------------------------------------------------+
// | tb_serial_sub : self-checking bench for serial_sub (N=4 and N=8 instances) |
// |                 against an arithmetic reference model.                     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_sub;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, start4, bout4, busy4, done4;
  logic [3:0] a4, b4, d4;
  logic       rst8, start8, bout8, busy8, done8;
  logic [7:0] a8, b8, d8;
`ifdef SERIAL_SUB_FLAGS_EN
  logic       zero4, ovf4, zero8, ovf8;
`endif

  int checks = 0;
  int errors = 0;

  serial_sub #(.N(4)) u_dut4 (
    .clock(clk), .reset(rst4), .start(start4), .a(a4), .b(b4),
    .d(d4), .bout(bout4), .busy(busy4), .done(done4)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(zero4), .ovf(ovf4)
`endif
  );

  serial_sub #(.N(8)) u_dut8 (
    .clock(clk), .reset(rst8), .start(start8), .a(a8), .b(b8),
    .d(d8), .bout(bout8), .busy(busy8), .done(done8)
`ifdef SERIAL_SUB_FLAGS_EN
    , .zero(zero8), .ovf(ovf8)
`endif
  );

  // Reference model: plain integer arithmetic on unsigned/signed values.
  function automatic int m_d(input int x, input int y, input int n);
    return (x - y) & ((1 << n) - 1);
  endfunction

  function automatic int m_bout(input int x, input int y);
    return (x < y) ? 1 : 0;
  endfunction

  function automatic int m_ovf(input int x, input int y, input int n);
    int sx, sy, diff;
    sx   = (x >= (1 << (n - 1))) ? x - (1 << n) : x;
    sy   = (y >= (1 << (n - 1))) ? y - (1 << n) : y;
    diff = sx - sy;
    return ((diff > (1 << (n - 1)) - 1) || (diff < -(1 << (n - 1)))) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result4(input int x, input int y);
    chk("d4", 32'(d4), m_d(x, y, 4));
    chk("bout4", 32'(bout4), m_bout(x, y));
`ifdef SERIAL_SUB_FLAGS_EN
    chk("zero4", 32'(zero4), (m_d(x, y, 4) == 0) ? 1 : 0);
    chk("ovf4", 32'(ovf4), m_ovf(x, y, 4));
`endif
  endtask

  // One operation on the N=4 instance; optional glitch pulses start mid-RUN.
  task automatic op4(input int x, input int y, input bit glitch);
    int nb;
    bit seen;
    @(negedge clk);
    a4 = 4'(x); b4 = 4'(y); start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4) begin
        seen = 1'b1;
        break;
      end
      if (busy4) nb++;
      if (glitch && i == 1) begin
        start4 = 1'b1; a4 = 4'd0; b4 = 4'd1;
      end else begin
        start4 = 1'b0;
      end
      @(negedge clk);
    end
    start4 = 1'b0;
    chk("done_seen4", 32'(seen), 1);
    chk("busy_cycles4", 32'(nb), 4);
    chk("busy_at_done4", 32'(busy4), 0);
    check_result4(x, y);
    @(negedge clk);
    chk("done_single4", 32'(done4), 0);
  endtask

  initial begin
    int qa, qb, cnt;
    bit seen;

    rst4 = 1'b1; rst8 = 1'b1;
    start4 = 1'b0; start8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("rst_d4", 32'(d4), 0);
    chk("rst_bout4", 32'(bout4), 0);
    chk("rst_busy4", 32'(busy4), 0);
    chk("rst_done4", 32'(done4), 0);
    chk("rst_d8", 32'(d8), 0);
    chk("rst_done8", 32'(done8), 0);
    rst4 = 1'b0; rst8 = 1'b0;

    // Directed N=4 cases.
    op4(9, 3, 1'b0);
    op4(3, 9, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold_d4", 32'(d4), 32'hA);
      chk("hold_done4", 32'(done4), 0);
    end
    op4(7, 8, 1'b0);
    op4(15, 15, 1'b0);
    op4(5, 1, 1'b1);

    // Randomized single operations.
    for (int k = 0; k < 16; k++) begin
      op4(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
    end

    // start held high: back-to-back operations, done every 5 cycles.
    @(negedge clk);
    qa = int'($urandom_range(0, 15)); qb = int'($urandom_range(0, 15));
    a4 = 4'(qa); b4 = 4'(qb); start4 = 1'b1;
    for (int op = 0; op < 6; op++) begin
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        cnt++;
        if (done4) begin
          seen = 1'b1;
          break;
        end
      end
      chk("b2b_seen", 32'(seen), 1);
      chk("b2b_period", 32'(cnt), 5);
      check_result4(qa, qb);
      qa = int'($urandom_range(0, 15)); qb = int'($urandom_range(0, 15));
      a4 = 4'(qa); b4 = 4'(qb);
      if (op == 5) start4 = 1'b0;
    end
    @(negedge clk);
    chk("b2b_end_done", 32'(done4), 0);
    chk("b2b_end_busy", 32'(busy4), 0);

    // N=8: complete one operation, then reset in the middle of the next.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done8) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen8", 32'(seen), 1);
    chk("d8", 32'(d8), m_d(32'h80, 1, 8));
    chk("bout8", 32'(bout8), m_bout(32'h80, 1));
`ifdef SERIAL_SUB_FLAGS_EN
    chk("ovf8", 32'(ovf8), m_ovf(32'h80, 1, 8));
`endif
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("busy8_before_rst", 32'(busy8), 1);
    rst8 = 1'b1;
    @(negedge clk);
    rst8 = 1'b0;
    chk("midrst_d8", 32'(d8), 0);
    chk("midrst_bout8", 32'(bout8), 0);
    chk("midrst_busy8", 32'(busy8), 0);
    chk("midrst_done8", 32'(done8), 0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("midrst_zero8", 32'(zero8), 0);
    chk("midrst_ovf8", 32'(ovf8), 0);
`endif
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen = 1'b1;
    end
    chk("midrst_no_done8", 32'(seen), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
